// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store initiator (mem_access_unit).
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Low address bits that select a byte within a word; cleared to form mem_adr.
  localparam logic [1:0] WORD_OFFSET_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = |lo;
    endcase
    return mis;
  endfunction

  // Forces offending low address bits to zero for the access size.
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] lane;
    case (size)
      SZ_BYTE: lane = lo;
      SZ_HALF: lane = {lo[1], 1'b0};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// lane_mux: load lane extraction/extension and store lane merge (little-endian).
module lane_mux
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Extract the addressed lane for loads and splice new lanes in for stores.
  always_comb begin
    load_data   = 32'h0000_0000;
    merged_word = rd_word;
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    case (size)
      SZ_BYTE: begin
        byte_s = rd_word[{lane, 3'b000} +: 8];
        if (is_unsigned) begin
          load_data = {24'h00_0000, byte_s};
        end else begin
          load_data = {{24{byte_s[7]}}, byte_s};
        end
        merged_word[{lane, 3'b000} +: 8] = wr_data[7:0];
      end
      SZ_HALF: begin
        if (lane[1]) begin
          half_s             = rd_word[31:16];
          merged_word[31:16] = wr_data[15:0];
        end else begin
          half_s             = rd_word[15:0];
          merged_word[15:0]  = wr_data[15:0];
        end
        if (is_unsigned) begin
          load_data = {16'h0000, half_s};
        end else begin
          load_data = {{16{half_s[15]}}, half_s};
        end
      end
      default: begin
        load_data   = rd_word;
        merged_word = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time byte/half/word load/store initiator with RMW sub-word stores.
// Optional build macro MISALIGN_TRAP_EN: misaligned requests respond with resp_err=1 and no memory access.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [1:0]          lane_q, lane_d;
  logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                accept_s;
  logic                trap_s;
  logic                word_store_s;
  logic [DATA_W-1:0]   load_data_s;
  logic [DATA_W-1:0]   merged_s;

  lane_mux u_lane_mux (
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (unsigned_q),
    .rd_word     (mem_read_data),
    .wr_data     (wdata_q),
    .load_data   (load_data_s),
    .merged_word (merged_s)
  );

  assign accept_s     = (state_q == IDLE) && req_valid;
  assign word_store_s = req_write && (req_size[1] == 1'b1);

  always_comb begin
`ifdef MISALIGN_TRAP_EN
    trap_s = is_misaligned(req_size, req_addr[1:0]);
`else
    trap_s = 1'b0;
`endif
  end

  // State register; reset drops mem_write immediately so no partial write commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (trap_s) begin
            state_d = RESP;
          end else if (word_store_s) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (write_q) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready  = 1'b1;
      READ:    mem_read   = 1'b1;
      WRITE:   mem_write  = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
    mem_adr        = mem_adr_q;
    mem_write_data = wdata_q;
    resp_rdata     = resp_rdata_q;
    resp_err       = resp_err_q;
  end

  // Request latch at accept; READ either finalises a load result or folds in the store lanes.
  always_comb begin
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    lane_d       = lane_q;
    mem_adr_d    = mem_adr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept_s) begin
      write_d      = req_write;
      size_d       = req_size;
      unsigned_d   = req_unsigned;
      lane_d       = align_lane(req_size, req_addr[1:0]);
      mem_adr_d    = req_addr & ~ADDR_W'(WORD_OFFSET_MASK);
      wdata_d      = req_wdata;
      resp_rdata_d = {DATA_W{1'b0}};
      resp_err_d   = trap_s;
    end else if (state_q == READ) begin
      if (write_q) begin
        wdata_d = merged_s;
      end else begin
        resp_rdata_d = load_data_s;
      end
    end else begin
      resp_err_d = resp_err_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      lane_q       <= 2'b00;
      mem_adr_q    <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      resp_rdata_q <= {DATA_W{1'b0}};
      resp_err_q   <= 1'b0;
    end else begin
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      lane_q       <= lane_d;
      mem_adr_q    <= mem_adr_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and response scoreboard.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_adr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int saw_read, saw_write, both_high, adr_bad;
  logic [31:0] wr_adr, wr_data;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_adr(mem_adr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem_read ? mem[mem_adr[11:2]] : 32'h0000_0000;

  always @(posedge clk) begin
    if (mem_write) mem[mem_adr[11:2]] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] adr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    exp_t e;
    logic [31:0] got_rd;
    logic got_err;
    int lat;
    bit seen;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = adr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    saw_read = 0; saw_write = 0; both_high = 0; adr_bad = 0;
    seen = 1'b0; lat = 0; got_rd = 32'h0; got_err = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      if (i > 1) @(negedge clk);
      if (mem_read) saw_read++;
      if (mem_write) begin saw_write++; wr_adr = mem_adr; wr_data = mem_write_data; end
      if (mem_read && mem_write) both_high++;
      if (mem_adr !== {adr[31:2], 2'b00}) adr_bad++;
      if (resp_valid) begin seen = 1'b1; lat = i; got_rd = resp_rdata; got_err = resp_err; end
    end
    e = sb.pop_front();
    chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_rdata"}, got_rd, e.rdata);
      chk({tag, "_err"}, 32'(got_err), 32'(e.err));
    end
    chk({tag, "_rd_wr_overlap"}, 32'(both_high), 32'd0);
    chk({tag, "_adr_held"}, 32'(adr_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] byte_exp [4];
    logic [31:0] hs_addr [3];
    logic [1:0]  hs_size [3];
    logic        hs_uns [3];
    logic [31:0] hs_exp [3];
    int accepts, resps, consec, late_resp;
    bit prev_resp;
    exp_t e;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load.
    do_req("st_word", 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    chk("st_word_writes", 32'(saw_write), 32'd1);
    chk("st_word_reads", 32'(saw_read), 32'd0);
    chk("st_word_adr", wr_adr, 32'h100);
    chk("st_word_data", wr_data, 32'hDEAD_BEEF);
    do_req("ld_word", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    chk("ld_word_reads", 32'(saw_read), 32'd1);

    // Byte and halfword loads, signed and unsigned.
    mem[32'h200 >> 2] = 32'h80FF_7F01;
    byte_exp[0] = 32'h0000_0001; byte_exp[1] = 32'h0000_007F;
    byte_exp[2] = 32'hFFFF_FFFF; byte_exp[3] = 32'hFFFF_FF80;
    for (int i = 0; i < 4; i++)
      do_req("ld_byte_s", 1'b0, SZ_BYTE, 1'b0, 32'h200 + 32'(i), 32'h0, byte_exp[i], 1'b0, 2);
    do_req("ld_byte_u", 1'b0, SZ_BYTE, 1'b1, 32'h203, 32'h0, 32'h0000_0080, 1'b0, 2);
    do_req("ld_half_s", 1'b0, SZ_HALF, 1'b0, 32'h202, 32'h0, 32'hFFFF_80FF, 1'b0, 2);
    do_req("ld_half_u", 1'b0, SZ_HALF, 1'b1, 32'h200, 32'h0, 32'h0000_7F01, 1'b0, 2);

    // Sub-word read-modify-write.
    do_req("st_w300", 1'b1, SZ_WORD, 1'b0, 32'h300, 32'h1122_3344, 32'h0, 1'b0, 2);
    do_req("st_half", 1'b1, SZ_HALF, 1'b0, 32'h302, 32'h0000_ABCD, 32'h0, 1'b0, 3);
    chk("st_half_reads", 32'(saw_read), 32'd1);
    chk("st_half_writes", 32'(saw_write), 32'd1);
    chk("st_half_wdata", wr_data, 32'hABCD_3344);
    chk("st_half_mem", mem[32'h300 >> 2], 32'hABCD_3344);
    do_req("st_byte", 1'b1, SZ_BYTE, 1'b0, 32'h301, 32'h0000_005A, 32'h0, 1'b0, 3);
    chk("st_byte_wdata", wr_data, 32'hABCD_5A44);
    do_req("ld_after_rmw", 1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0, 32'hABCD_5A44, 1'b0, 2);

    // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
    do_req("mis_ld", 1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    chk("mis_ld_reads", 32'(saw_read), 32'd0);
`else
    do_req("mis_ld", 1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    chk("mis_ld_reads", 32'(saw_read), 32'd1);
`endif

    // Reset while a byte store sits in WRITE.
    mem[32'h400 >> 2] = 32'h5566_7788;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = 32'h401; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstw_pre_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_mem_write", 32'(mem_write), 32'd0);
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_resp_err", 32'(resp_err), 32'd0);
    chk("rstw_rdata", resp_rdata, 32'h0);
    chk("rstw_mem_read", 32'(mem_read), 32'd0);
    chk("rstw_mem_adr", mem_adr, 32'h0);
    chk("rstw_wdata", mem_write_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rstw_mem_word", mem[32'h400 >> 2], 32'h5566_7788);
    rst_n = 1'b1;
    late_resp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) late_resp++;
    end
    chk("rstw_no_resp", 32'(late_resp), 32'd0);

    // Held req_valid across three requests.
    hs_addr[0] = 32'h100; hs_size[0] = SZ_WORD; hs_uns[0] = 1'b0; hs_exp[0] = 32'hDEAD_BEEF;
    hs_addr[1] = 32'h202; hs_size[1] = SZ_BYTE; hs_uns[1] = 1'b0; hs_exp[1] = 32'hFFFF_FFFF;
    hs_addr[2] = 32'h302; hs_size[2] = SZ_HALF; hs_uns[2] = 1'b1; hs_exp[2] = 32'h0000_ABCD;
    accepts = 0; resps = 0; consec = 0; prev_resp = 1'b0;
    req_write = 1'b0; req_wdata = 32'h0;
    for (int cyc = 0; cyc < 40 && !(accepts == 3 && resps == 3); cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        resps++;
        if (prev_resp) consec++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("hs_rdata", resp_rdata, e.rdata);
          chk("hs_err", 32'(resp_err), 32'(e.err));
        end else begin
          chk("hs_unexpected_resp", 32'(resps), 32'(accepts));
        end
      end
      prev_resp = resp_valid;
      if (accepts == 3) begin
        req_valid = 1'b0;
      end else begin
        req_valid = 1'b1;
        req_addr = hs_addr[accepts]; req_size = hs_size[accepts]; req_unsigned = hs_uns[accepts];
        if (req_ready) begin
          e.rdata = hs_exp[accepts]; e.err = 1'b0; e.lat = 2;
          sb.push_back(e);
          accepts++;
        end
      end
    end
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) resps++;
    end
    chk("hs_accepts", 32'(accepts), 32'd3);
    chk("hs_resps", 32'(resps), 32'd3);
    chk("hs_consecutive", 32'(consec), 32'd0);
    chk("hs_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
